vram_write_arbiter: RTL and testbench
=====================================

// Module: vram_write_arbiter
// PURPOSE
//   Shares the single framebuffer write port between NUM_REQ compute cores with a round-robin policy.
//   Sits between the manycore array and the dual-port VRAM; the VGA controller owns the read port.
//   Sequences one frame at a time: arms on frame_start, counts written pixels, drains, then pulses frame_done.
// PARAMETERS
//   NUM_REQ       8      number of requesting cores (1..64)
//   ADDR_W        18     VRAM address width (fractaski_vram_pkg::ADDR_W)
//   DATA_W        8      pixel width (fractaski_vram_pkg::DATA_W)
//   FRAME_PIXELS  76800  pixels per frame (320x240); must be <= 2**ADDR_W
// PORTS
//   clk           in   1                 system clock (MMCM clkout0 domain)
//   reset_n       in   1                 asynchronous, active-low reset
//   frame_start   in   1                 arm a new frame; honoured only in IDLE
//   req_valid     in   NUM_REQ           per-core write request
//   req_addr      in   NUM_REQ*ADDR_W    per-core pixel address, packed, core i at [i*ADDR_W +: ADDR_W]
//   req_data      in   NUM_REQ*DATA_W    per-core pixel value, packed likewise
//   req_ready     out  NUM_REQ           one-hot accept; transfer when req_valid[i] & req_ready[i]
//   vram_we       out  1                 write strobe to VRAM port A
//   vram_addr     out  ADDR_W            write address
//   vram_wdata    out  DATA_W            write data
//   vram_ready    in   1                 VRAM accepts the write this cycle (tie 1 for BRAM)
//   busy          out  1                 state != IDLE
//   frame_done    out  1                 1-cycle pulse when a frame has fully reached VRAM
//   oob_err       out  1                 sticky: an out-of-range address was dropped this frame
// BEHAVIOUR
//   Reset (reset_n=0, async): state=IDLE, rr_ptr=0, count=0. All outputs 0: req_ready, vram_we, vram_addr, vram_wdata, busy, frame_done, oob_err.
//   FSM states (fractaski_vram_pkg::arb_state_t):
//     IDLE   -> RUN on frame_start. Clears count and oob_err. req_ready=0.
//     RUN    grants. -> DRAIN in the cycle count reaches FRAME_PIXELS. frame_start is ignored.
//     DRAIN  no grants. -> DONE when the output register is empty or draining this cycle (vram_ready).
//     DONE   frame_done=1 for exactly one cycle, then -> IDLE.
//   Output register: one-deep (vram_we/addr/wdata). "Free" = !vram_we | vram_ready.
//   Grant (RUN and free only):
//     - Winner = first valid index scanning rr_ptr, rr_ptr+1 .. wrapping mod NUM_REQ.
//     - req_ready is combinational from req_valid, rr_ptr, state and free; at most one bit set.
//     - On a grant to k, rr_ptr <= (k+1) mod NUM_REQ. With no grant, rr_ptr holds.
//   Latency: accepted request appears on vram_we/addr/wdata next cycle and holds until vram_ready.
//   Throughput: 1 write/cycle with vram_ready=1.
//   Range check: req_addr >= FRAME_PIXELS is still accepted (req_ready=1), so the core never stalls.
//     - Not forwarded (output register unchanged), not counted.
//     - oob_err <= 1 and stays 1 until the next IDLE->RUN.
//   count: clog2(FRAME_PIXELS+1) bits; increments per forwarded accept. Never exceeds FRAME_PIXELS.
//   Boundaries:
//     - Last pixel accepted: same cycle count==FRAME_PIXELS-1 -> next cycle DRAIN; later requests wait.
//     - vram_ready=0 at frame end: stays in DRAIN until the held write drains. frame_done never precedes the last vram_we&vram_ready.
//     - frame_start with frame_done in the same cycle: ignored (state is DONE, not IDLE).
//     - Async reset mid-frame: in-flight write discarded, vram_we drops immediately, no frame_done.
// STRUCTURE
//   Package fractaski_vram_pkg:
//     - ADDR_W, DATA_W, FRAME_PIXELS default
//     - typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} arb_state_t
//   Sub-module rr_arbiter #(NUM_REQ): in req, ptr, en; out one-hot gnt, gnt_idx, any.
//     Purely combinational. Uses a double-width mask trick.
//   Top holds the FSM, rr_ptr, output register, count and oob_err.
// TESTING
//   T1 reset: reset_n=0 with all req_valid=1
//      -> every output 0; reset_n=1 without frame_start -> req_ready stays 0.
//   T2 fairness: FRAME_PIXELS=16, NUM_REQ=4, all valid, vram_ready=1
//      -> grants 0,1,2,3,0,1,.. (4 each); frame_done exactly 1 cycle after the 16th vram_we.
//   T3 backpressure: single requester, vram_ready toggles 1,0,0,1
//      -> vram_addr/wdata stable while vram_ready=0; no write lost or duplicated; scoreboard matches.
//   T4 out-of-range: core 2 writes addr=FRAME_PIXELS, data=8'hAA
//      -> req_ready[2]=1, no vram_we, oob_err=1, count unchanged; next frame_start clears oob_err.
//   T5 frame end under stall: last pixel with vram_ready=0 for 5 cycles
//      -> state DRAIN for 5 cycles, no grants, frame_done pulses after drain; frame_start during DRAIN ignored.
//   T6 async reset mid-frame: assert reset_n=0 after 7 writes
//      -> vram_we=0 asynchronously; after release count=0, state IDLE, no frame_done.

Source files
------------

// File: rtl/vram_write_arbiter_pkg.sv
// Shared constants and state type for the framebuffer write arbiter.
package fractaski_vram_pkg;

  localparam int ADDR_W       = 18;
  localparam int DATA_W       = 8;
  localparam int FRAME_PIXELS = 76800;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vram_write_arbiter_rr.sv
// Combinational round-robin picker: the request vector is rotated so that
// bit 0 lines up with ptr, the lowest set bit wins, and the offset is
// mapped back to an absolute index.
module rr_arbiter #(
  parameter int NUM_REQ = 8
) (
  input  logic [NUM_REQ-1:0]                             req,
  input  logic [fractaski_vram_pkg::idx_w(NUM_REQ)-1:0]  ptr,
  input  logic                                           en,
  output logic [NUM_REQ-1:0]                             gnt,
  output logic [fractaski_vram_pkg::idx_w(NUM_REQ)-1:0]  gnt_idx,
  output logic                                           any
);
  import fractaski_vram_pkg::*;

  localparam int PTR_W = idx_w(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [PTR_W-1:0]     off;
  logic [PTR_W:0]       sum;
  logic                 found;

  // Rotate by ptr, find first set bit, map back modulo NUM_REQ.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[NUM_REQ-1:0];
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = PTR_W'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
    any     = found && en;
    gnt_idx = sum[PTR_W-1:0];
    gnt     = '0;
    if (any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// Round-robin arbiter for the single VRAM write port, sequenced per frame.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for frame_start; no grants
// RUN   | granting cores until FRAME_PIXELS in-range pixels are taken
// DRAIN | no grants; waiting for the held write to leave the register
// DONE  | frame_done high for one cycle, then back to IDLE
module vram_write_arbiter #(
  parameter int NUM_REQ      = 8,
  parameter int ADDR_W       = fractaski_vram_pkg::ADDR_W,
  parameter int DATA_W       = fractaski_vram_pkg::DATA_W,
  parameter int FRAME_PIXELS = fractaski_vram_pkg::FRAME_PIXELS
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      frame_start,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      vram_we,
  output logic [ADDR_W-1:0]         vram_addr,
  output logic [DATA_W-1:0]         vram_wdata,
  input  logic                      vram_ready,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      oob_err
);
  import fractaski_vram_pkg::*;

  localparam int PTR_W = idx_w(NUM_REQ);
  localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
  localparam logic [ADDR_W:0]  PIX_LIMIT = (ADDR_W+1)'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  arb_state_t        state, state_nxt;
  logic [PTR_W-1:0]  rr_ptr, gnt_idx;
  logic [CNT_W-1:0]  count;
  logic              free, grant_en, any_gnt, in_range, fwd, drop;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // The output register can take a new write when empty or emptying now.
  assign free     = !vram_we || vram_ready;
  assign grant_en = (state == RUN) && free;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .en      (grant_en),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx),
    .any     (any_gnt)
  );

  assign sel_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_data = req_data[gnt_idx*DATA_W +: DATA_W];
  // Out-of-range pixels are still accepted so a faulty core cannot stall the array.
  assign in_range = {1'b0, sel_addr} < PIX_LIMIT;
  assign fwd      = any_gnt && in_range;
  assign drop     = any_gnt && !in_range;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    frame_done = 1'b0;
    case (state)
      IDLE:    if (frame_start) state_nxt = RUN;
      RUN:     if (fwd && (count == LAST_PIX)) state_nxt = DRAIN;
      DRAIN:   if (free) state_nxt = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One-deep output register; holds its write until VRAM takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= '0;
    end else if (fwd) begin
      vram_we    <= 1'b1;
      vram_addr  <= sel_addr;
      vram_wdata <= sel_data;
    end else if (vram_ready) begin
      vram_we    <= 1'b0;
    end
  end

  // Round-robin pointer moves just past the last winner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     rr_ptr <= '0;
    else if (any_gnt) rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
  end

  // Pixel count and sticky range error, both cleared when a frame is armed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      oob_err <= 1'b0;
    end else if ((state == IDLE) && frame_start) begin
      count   <= '0;
      oob_err <= 1'b0;
    end else begin
      if (fwd)  count   <= count + 1'b1;
      if (drop) oob_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter: random requests against a frame-level model
// with a write scoreboard, plus directed reset/fairness/stall/range scenarios.
module tb_vram_write_arbiter;
  localparam int N  = 4;
  localparam int AW = 18;
  localparam int DW = 8;
  localparam int FP = 16;

  logic            clk, reset_n, frame_start, vram_ready;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            vram_we, busy, frame_done, oob_err;
  logic [AW-1:0]   vram_addr;
  logic [DW-1:0]   vram_wdata;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 running, 2 draining, 3 done.
  int            m_st, m_ptr, m_count;
  logic          m_oob, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  logic [AW-1:0] addr_a [N];
  logic [DW-1:0] data_a [N];
  int            oob_pct    = 0;
  int            force_core = -1;
  logic [AW+DW-1:0] sb [$];
  int call_n = 0, wr_n = 0, last_wr_call = -1, done_call = -1, s5 = 0;
  int gnt_cnt [N];

  vram_write_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .FRAME_PIXELS(FP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_ready(vram_ready), .busy(busy),
    .frame_done(frame_done), .oob_err(oob_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_ptr = 0; m_count = 0; m_oob = 1'b0;
    m_we = 1'b0; m_addr = '0; m_data = '0;
  endtask

  // First valid core scanning from the model pointer, or -1.
  function automatic int exp_grant();
    if (m_st != 1) return -1;
    if (m_we && !vram_ready) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge(input int g);
    logic was_free;
    was_free = !m_we || vram_ready;
    if (vram_ready) m_we = 1'b0;
    case (m_st)
      0: if (frame_start) begin m_st = 1; m_count = 0; m_oob = 1'b0; end
      1: if (g >= 0) begin
           m_ptr = (g + 1) % N;
           if (addr_a[g] < FP) begin
             m_we = 1'b1; m_addr = addr_a[g]; m_data = data_a[g];
             m_count++;
             if (m_count == FP) m_st = 2;
           end else m_oob = 1'b1;
         end
      2: if (was_free) m_st = 3;
      default: m_st = 0;
    endcase
  endtask

  // One clock: entered just after a rising edge, leaves just after the next.
  task automatic drive_cycle(input logic fs, input logic [N-1:0] v, input logic rdy);
    int g;
    logic [31:0] er;
    logic [AW+DW-1:0] e;
    call_n++;
    check("vram_we", vram_we, m_we);
    check("vram_addr", vram_addr, m_addr);
    check("vram_wdata", vram_wdata, m_data);
    check("busy", busy, (m_st != 0));
    check("frame_done", frame_done, (m_st == 3));
    check("oob_err", oob_err, m_oob);
    if (frame_done) done_call = call_n;
    frame_start = fs; req_valid = v; vram_ready = rdy;
    for (int i = 0; i < N; i++) begin
      data_a[i] = DW'($urandom);
      if (i == force_core) begin
        addr_a[i] = AW'(FP); data_a[i] = 8'hAA;
      end else if ($urandom_range(0, 99) < oob_pct) addr_a[i] = AW'(FP + $urandom_range(0, 40));
      else addr_a[i] = AW'($urandom_range(0, FP - 1));
      req_addr[i*AW +: AW] = addr_a[i];
      req_data[i*DW +: DW] = data_a[i];
    end
    #1;
    g  = exp_grant();
    er = (g >= 0) ? (32'd1 << g) : 32'd0;
    check("req_ready", req_ready, er);
    if (vram_we && vram_ready) begin
      check("sb_write_expected", (sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_write", {vram_addr, vram_wdata}, e);
      end
      wr_n++;
      if (wr_n == FP) last_wr_call = call_n;
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        gnt_cnt[i]++;
        if (addr_a[i] < FP) sb.push_back({addr_a[i], data_a[i]});
      end
    end
    @(posedge clk);
    model_edge(g);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; frame_start = 1'b0; vram_ready = 1'b0;
    req_valid = '1; req_addr = '0; req_data = '0;
    model_reset();

    // T1: reset with every core requesting
    #3;
    check("t1_req_ready", req_ready, 0);
    check("t1_vram_we", vram_we, 0);
    check("t1_vram_addr", vram_addr, 0);
    check("t1_vram_wdata", vram_wdata, 0);
    check("t1_busy", busy, 0);
    check("t1_frame_done", frame_done, 0);
    check("t1_oob_err", oob_err, 0);
    @(posedge clk); #1;
    check("t1_req_ready_edge", req_ready, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    repeat (3) drive_cycle(1'b0, '1, 1'b1);

    // T2: fairness with all cores valid and no backpressure
    foreach (gnt_cnt[i]) gnt_cnt[i] = 0;
    wr_n = 0; done_call = -1;
    drive_cycle(1'b1, '1, 1'b1);
    for (int c = 0; c < 40 && m_st != 0; c++) drive_cycle(1'b0, '1, 1'b1);
    check("t2_idle", busy, 0);
    for (int i = 0; i < N; i++) check("t2_grants_per_core", gnt_cnt[i], FP / N);
    check("t2_done_latency", done_call - last_wr_call, 1);

    // T3: single requester under backpressure pattern 1,0,0,1
    drive_cycle(1'b1, '0, 1'b1);
    for (int c = 0; c < 150 && m_st != 0; c++)
      drive_cycle(1'b0, 4'b0010, ((c % 4) == 0) || ((c % 4) == 3));
    check("t3_idle", busy, 0);
    check("t3_sb_empty", sb.size(), 0);

    // T4: out-of-range address from core 2
    drive_cycle(1'b1, '0, 1'b1);
    force_core = 2;
    drive_cycle(1'b0, 4'b0100, 1'b1);
    force_core = -1;
    check("t4_oob_set", oob_err, 1);
    check("t4_no_write", vram_we, 0);
    for (int c = 0; c < 80 && m_st != 0; c++) drive_cycle(1'b0, N'($urandom), 1'b1);
    check("t4_oob_sticky", oob_err, 1);
    drive_cycle(1'b1, '0, 1'b1);
    check("t4_oob_cleared", oob_err, 0);

    // T5: last pixel held by a 5-cycle stall, frame_start during DRAIN
    done_call = -1;
    for (int c = 0; c < 60 && m_st == 1; c++) drive_cycle(1'b0, '1, 1'b1);
    repeat (5) drive_cycle(1'b1, '1, 1'b0);
    s5 = call_n;
    for (int c = 0; c < 10 && m_st != 0; c++) drive_cycle(1'b0, '1, 1'b1);
    check("t5_done_after_drain", done_call - s5, 2);
    check("t5_idle", busy, 0);

    // T6: asynchronous reset after 7 writes
    done_call = -1;
    drive_cycle(1'b1, '1, 1'b1);
    for (int c = 0; c < 20 && m_count < 7; c++) drive_cycle(1'b0, '1, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_we_async", vram_we, 0);
    check("t6_busy_async", busy, 0);
    check("t6_ready_async", req_ready, 0);
    check("t6_done_async", frame_done, 0);
    model_reset();
    sb.delete();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    repeat (3) drive_cycle(1'b0, '1, 1'b1);
    check("t6_no_frame_done", done_call, -1);
    wr_n = 0;
    drive_cycle(1'b1, '1, 1'b1);
    for (int c = 0; c < 40 && m_st != 0; c++) drive_cycle(1'b0, '1, 1'b1);
    check("t6_full_frame_writes", wr_n, FP);

    // Random frames with backpressure and occasional bad addresses
    oob_pct = 15;
    for (int f = 0; f < 3; f++) begin
      drive_cycle(1'b1, N'($urandom), ($urandom_range(0, 3) != 0));
      for (int c = 0; c < 300 && m_st != 0; c++)
        drive_cycle(1'b0, N'($urandom), ($urandom_range(0, 3) != 0));
      check("rand_frame_idle", busy, 0);
      check("rand_sb_empty", sb.size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
